condiciona_chaves: RTL and testbench

CONDICIONA_CHAVES -- requirements
Module: condiciona_chaves

---
 rtl/condiciona_chaves.sv | 132 +++++++++++++
 tb/tb_condiciona_chaves.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/condiciona_chaves.sv
// Switch conditioner: synchronizes and debounces six player switches, emits one
// event per press into a small show-ahead FIFO with drop counting and flush.
module sync_bit (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

module condiciona_chaves #(
  parameter int DEBOUNCE_CICLOS = 16,
  parameter int PROFUNDIDADE    = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] chaves,
  input  logic       habilita,
  input  logic       consome,
  output logic       jogada_valida,
  output logic [5:0] jogada,
  output logic       fila_cheia,
  output logic [3:0] descartados,
  output logic [3:0] db_estado
);
  localparam int AW = $clog2(PROFUNDIDADE);
  localparam int CW = $clog2(PROFUNDIDADE) + 1;
  localparam int DW = $clog2(DEBOUNCE_CICLOS) + 1;
  localparam logic [DW-1:0] LIM = DW'(DEBOUNCE_CICLOS - 1);

  localparam logic [2:0] OCIOSO         = 3'd0;
  localparam logic [2:0] FILTRA_PRESSAO = 3'd1;
  localparam logic [2:0] REGISTRA       = 3'd2;
  localparam logic [2:0] SEGURA         = 3'd3;
  localparam logic [2:0] FILTRA_SOLTURA = 3'd4;

  logic [5:0]    s;
  logic [5:0]    cand;
  logic [DW-1:0] cnt;
  logic [2:0]    st, nxt;

  for (genvar i = 0; i < 6; i++) begin : g_sync
    sync_bit u_sync (.clock(clock), .reset(reset), .d(chaves[i]), .q(s[i]));
  end

  // Candidate always follows s; cnt is the number of consecutive cycles it has matched.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cand <= '0;
      cnt  <= '0;
    end else if (s != cand) begin
      cand <= s;
      cnt  <= '0;
    end else if (cnt != LIM) begin
      cnt <= cnt + DW'(1);
    end
  end

  always_comb begin
    nxt = st;
    case (st)
      OCIOSO:         if (s != 6'd0) nxt = FILTRA_PRESSAO;
      FILTRA_PRESSAO: if (s == 6'd0) nxt = OCIOSO;
                      else if (s == cand && cnt == LIM) nxt = REGISTRA;
      REGISTRA:       nxt = SEGURA;
      SEGURA:         if (s == 6'd0) nxt = FILTRA_SOLTURA;
      FILTRA_SOLTURA: if (s != 6'd0) nxt = SEGURA;
                      else if (s == cand && cnt == LIM) nxt = OCIOSO;
      default:        nxt = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) st <= OCIOSO;
    else        st <= nxt;
  end

  assign db_estado = {1'b0, st};

  logic [5:0]    mem [PROFUNDIDADE];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] ocup;
  logic          hab_q, flush, push, pop, wr_en, drop;

  assign flush  = hab_q && !habilita;
  assign push   = (st == REGISTRA) && habilita;
  assign pop    = consome && (ocup != '0);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign wr_en  = push && (!fila_cheia || pop);
  assign drop   = push && fila_cheia && !pop;

  always_ff @(posedge clock) begin
    if (wr_en && !flush) mem[wr_ptr] <= cand;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ocup        <= '0;
      hab_q       <= 1'b0;
      descartados <= '0;
    end else begin
      hab_q <= habilita;
      if (flush) begin
        rd_ptr <= wr_ptr;
        ocup   <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + AW'(1);
        if (pop)   rd_ptr <= rd_ptr + AW'(1);
        if (wr_en && !pop)      ocup <= ocup + CW'(1);
        else if (pop && !wr_en) ocup <= ocup - CW'(1);
        if (drop && descartados != 4'hF) descartados <= descartados + 4'd1;
      end
    end
  end

  assign jogada_valida = (ocup != '0);
  assign fila_cheia    = (ocup == CW'(PROFUNDIDADE));
  assign jogada        = jogada_valida ? mem[rd_ptr] : 6'd0;
endmodule

// File: tb/tb_condiciona_chaves.sv
// Bench for condiciona_chaves: directed scenarios plus random presses, all
// checked each cycle against a queue-based model of press events and the FIFO.
module tb_condiciona_chaves;
  localparam int DEB = 16;
  localparam int DEP = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] chaves = '0;
  logic       habilita = 1'b0;
  logic       consome = 1'b0;
  logic       jogada_valida, fila_cheia;
  logic [5:0] jogada;
  logic [3:0] descartados, db_estado;

  always #5 clock = ~clock;

  condiciona_chaves #(.DEBOUNCE_CICLOS(DEB), .PROFUNDIDADE(DEP)) dut (
    .clock(clock), .reset(reset), .chaves(chaves), .habilita(habilita),
    .consome(consome), .jogada_valida(jogada_valida), .jogada(jogada),
    .fila_cheia(fila_cheia), .descartados(descartados), .db_estado(db_estado)
  );

  int n_vec = 0, n_err = 0, edge_n = 0, last_rise = 0;
  logic valid_prev = 1'b0;
  logic [5:0] q[$];
  int drops = 0;
  bit hab_prev = 1'b0;
  int sch_edge[$];
  logic [5:0] sch_val[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    sch_edge.delete();
    sch_val.delete();
    drops = 0;
    hab_prev = 1'b0;
    valid_prev = 1'b0;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".valida"}, 32'(jogada_valida), 32'(q.size() != 0));
    chk({tag, ".jogada"}, 32'(jogada), 32'(q.size() != 0 ? q[0] : 6'd0));
    chk({tag, ".cheia"}, 32'(fila_cheia), 32'(q.size() == DEP));
    chk({tag, ".descartados"}, 32'(descartados), 32'(drops));
  endtask

  // One clock edge: advance the model with the inputs present at the edge, then compare.
  task automatic step();
    logic h, c, pend, pop, push;
    logic [5:0] pv;
    h = habilita;
    c = consome;
    pv = '0;
    @(posedge clock);
    edge_n++;
    pend = 1'b0;
    if (sch_edge.size() > 0 && sch_edge[0] == edge_n) begin
      pend = 1'b1;
      pv = sch_val.pop_front();
      void'(sch_edge.pop_front());
    end
    if (hab_prev && !h) q.delete();
    else begin
      pop  = c && (q.size() > 0);
      push = pend && h;
      if (push && pop) begin
        void'(q.pop_front());
        q.push_back(pv);
      end else if (pop) void'(q.pop_front());
      else if (push) begin
        if (q.size() < DEP) q.push_back(pv);
        else if (drops < 15) drops++;
      end
    end
    hab_prev = h;
    #1;
    check_outs("ciclo");
    if (jogada_valida && !valid_prev) last_rise = edge_n;
    valid_prev = jogada_valida;
  endtask

  // A press counts once chaves stays put for DEB+1 sampling edges; its push
  // lands DEB+4 edges after the first edge that samples it.
  // cmode: 0 no pops, 1 random pops, 2 pop exactly on the push edge.
  task automatic press(input logic [5:0] v, input int hold, input int rel,
                       input int cmode, input logic [5:0] alt);
    int pe;
    pe = edge_n + DEB + 4;
    if (hold >= DEB + 1) begin
      sch_edge.push_back(pe);
      sch_val.push_back(v);
    end
    chaves = v;
    for (int i = 0; i < hold + rel; i++) begin
      if (i == hold) chaves = '0;
      else if (i == DEB + 2 && alt != 0 && i < hold) chaves = alt;
      case (cmode)
        1:       consome = ($urandom_range(0, 3) == 0);
        2:       consome = (edge_n + 1 == pe);
        default: consome = 1'b0;
      endcase
      step();
    end
    consome = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    chaves = '0;
    #1;
    model_reset();
    check_outs(tag);
    chk({tag, ".estado"}, 32'(db_estado), 32'd0);
    #2 reset = 1'b1;
  endtask

  task automatic drain(input int n);
    consome = 1'b1;
    repeat (n) step();
    consome = 1'b0;
  endtask

  initial begin
    int start, hold, rel;
    logic [5:0] v, alt;

    #1 reset = 1'b0;
    #1;
    check_outs("reset");
    chk("reset.estado", 32'(db_estado), 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;

    habilita = 1'b1;
    repeat (3) step();

    // Single clean press: first entry visible 20 edges after the change.
    start = edge_n;
    press(6'b100001, 30, DEB + 4, 0, 6'd0);
    chk("req033.latencia", 32'(last_rise - start), 32'd20);
    chk("req033.jogada", 32'(jogada), 32'(6'b100001));
    drain(2);

    // Bouncing input never settles long enough to register.
    for (int i = 0; i < 60; i++) begin
      chaves = ((i / 5) % 2 == 0) ? 6'b100001 : 6'd0;
      step();
      chk("req034.estado", 32'(db_estado != 4'd2), 32'd1);
    end
    chaves = '0;
    repeat (DEB + 4) step();

    // Changing pattern while held yields only the first pattern.
    press(6'b100001, 30, DEB + 4, 0, 6'b000010);
    chk("req037.jogada", 32'(jogada), 32'(6'b100001));
    drain(2);

    // Overfill: fifth press is dropped.
    press(6'h11, DEB + 4, DEB + 4, 0, 6'd0);
    press(6'h22, DEB + 4, DEB + 4, 0, 6'd0);
    press(6'h33, DEB + 4, DEB + 4, 0, 6'd0);
    press(6'h0C, DEB + 4, DEB + 4, 0, 6'd0);
    chk("req035.cheia", 32'(fila_cheia), 32'd1);
    press(6'h3F, DEB + 4, DEB + 4, 0, 6'd0);
    chk("req035.descartados", 32'(descartados), 32'd1);
    chk("req035.jogada", 32'(jogada), 32'h11);

    // Falling habilita flushes but keeps the drop count.
    habilita = 1'b0;
    step();
    chk("req028.valida", 32'(jogada_valida), 32'd0);
    chk("req028.descartados", 32'(descartados), 32'd1);

    // Press while disabled produces nothing.
    press(6'h15, 25, DEB + 4, 0, 6'd0);
    habilita = 1'b1;
    step();
    chk("req027.valida", 32'(jogada_valida), 32'd0);

    // Push and pop on the same edge with a full FIFO.
    async_reset("req036.reset");
    step();
    press(6'h01, DEB + 4, DEB + 4, 0, 6'd0);
    press(6'h02, DEB + 4, DEB + 4, 0, 6'd0);
    press(6'h04, DEB + 4, DEB + 4, 0, 6'd0);
    press(6'h08, DEB + 4, DEB + 4, 0, 6'd0);
    press(6'h10, DEB + 4, DEB + 4, 2, 6'd0);
    chk("req036.descartados", 32'(descartados), 32'd0);
    chk("req036.cheia", 32'(fila_cheia), 32'd1);
    chk("req036.jogada", 32'(jogada), 32'h02);

    // Reset mid-filter with two entries queued loses everything.
    drain(2);
    chaves = 6'h2A;
    repeat (8) step();
    async_reset("req038.reset");
    repeat (DEB + 10) step();
    chk("req038.vazio", 32'(jogada_valida), 32'd0);
    habilita = 1'b1;
    start = edge_n;
    press(6'h2A, 25, DEB + 4, 0, 6'd0);
    chk("req038.latencia", 32'(last_rise - start), 32'd20);
    drain(2);

    // Random presses of mixed length with random pops.
    for (int k = 0; k < 14; k++) begin
      v    = 6'($urandom_range(1, 63));
      hold = $urandom_range(3, DEB + 12);
      rel  = DEB + 3 + $urandom_range(0, 6);
      alt  = (hold > DEB + 3 && $urandom_range(0, 1) == 1) ? 6'($urandom_range(1, 63)) : 6'd0;
      press(v, hold, rel, 1, alt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
